// File: rtl/arb_pkg.sv
// Shared types for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/prio_pick.sv
// Combinational pick of the first set request at or above a start index, wrapping at NUM-1.
module prio_pick #(
  parameter  int NUM   = 4,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [IDX_W-1:0] start,
  output logic [NUM-1:0]   onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [NUM-1:0]   rot;
  logic [IDX_W-1:0] lo_idx;
  logic [IDX_W:0]   sum;

  // Rotating the doubled vector puts req[start] at bit 0.
  assign rot = NUM'({req, req} >> start);
  assign any = |req;

  always_comb begin
    lo_idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (rot[i]) lo_idx = IDX_W'(i);
    end
    sum = {1'b0, start} + {1'b0, lo_idx};
    if (sum >= (IDX_W + 1)'(NUM)) sum = sum - (IDX_W + 1)'(NUM);
    idx    = any ? sum[IDX_W-1:0] : '0;
    onehot = any ? ({{(NUM - 1){1'b0}}, 1'b1} << idx) : '0;
  end

endmodule

// File: rtl/rr_prio_arbiter_sva.sv
// Invariant checks for rr_prio_arbiter, attached to every instance by bind.
module rr_prio_arbiter_sva #(
  parameter  int NUM   = 4,
  localparam int IDX_W = $clog2(NUM)
) (
  input logic             clk,
  input logic             rst_n,
  input logic [NUM-1:0]   req,
  input logic [NUM-1:0]   gnt,
  input logic             gnt_valid,
  input logic [IDX_W-1:0] ptr
);

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));

  a_valid : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));

  // A grant can only go to a requester that was asking on the previous cycle.
  a_gnt_req : assert property (@(posedge clk) disable iff (!rst_n)
    (|gnt) |-> ((gnt & $past(req)) != '0));

  a_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, ptr} < (IDX_W + 1)'(NUM));

endmodule

bind rr_prio_arbiter rr_prio_arbiter_sva #(.NUM(NUM)) u_sva (
  .clk       (clk_i),
  .rst_n     (rst_ni),
  .req       (req_i),
  .gnt       (gnt_o),
  .gnt_valid (gnt_valid_o),
  .ptr       (ptr)
);

// File: rtl/rr_prio_arbiter.sv
// Registered arbiter with run-time fixed/round-robin policy and locked grants.
//   state     | meaning
//   ARB_IDLE  | no grant held; arbitrate every cycle
//   ARB_GRANT | grant held until ack_i or the winner drops its request
module rr_prio_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM   = 4,
  localparam int IDX_W = $clog2(NUM)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic [NUM-1:0]   req_i,
  input  logic             ack_i,
  output logic [NUM-1:0]   gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  arb_state_e       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, ptr_adv, start;
  logic [NUM-1:0]   gnt_nxt, pick_onehot;
  logic [IDX_W-1:0] idx_nxt, pick_idx;
  logic             pick_any, arb_point, rr_mode;

  prio_pick #(.NUM(NUM)) u_pick (
    .req    (req_i),
    .start  (start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    arb_point = (state == ARB_IDLE) || ack_i;
    rr_mode   = (arb_mode_e'(mode_i) == ARB_RR);
    // Explicit wrap so non-power-of-two NUM never overflows into an invalid index.
    ptr_adv   = (gnt_idx_o == IDX_W'(NUM - 1)) ? '0 : gnt_idx_o + 1'b1;
    ptr_nxt   = ptr;
    if (state == ARB_GRANT && ack_i && rr_mode) ptr_nxt = ptr_adv;
    start     = rr_mode ? ptr_nxt : '0;

    state_nxt = state;
    gnt_nxt   = gnt_o;
    idx_nxt   = gnt_idx_o;
    if (arb_point) begin
      if (pick_any) begin
        state_nxt = ARB_GRANT;
        gnt_nxt   = pick_onehot;
        idx_nxt   = pick_idx;
      end else begin
        state_nxt = ARB_IDLE;
        gnt_nxt   = '0;
        idx_nxt   = '0;
      end
    end else if (!req_i[gnt_idx_o]) begin
      state_nxt = ARB_IDLE;
      gnt_nxt   = '0;
      idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_o     <= gnt_nxt;
      gnt_idx_o <= idx_nxt;
    end
  end

  assign gnt_valid_o = |gnt_o;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Directed bench for rr_prio_arbiter: a NUM=4 instance plus a NUM=3 instance for pointer wrap.
module tb_rr_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode4, ack4, mode3, ack3;
  logic [3:0] req4, gnt4, idx4_unused_guard;
  logic [1:0] idx4, idx3;
  logic [2:0] req3, gnt3;
  logic       vld4, vld3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_prio_arbiter #(.NUM(4)) u_dut4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_i      (mode4),
    .req_i       (req4),
    .ack_i       (ack4),
    .gnt_o       (gnt4),
    .gnt_valid_o (vld4),
    .gnt_idx_o   (idx4)
  );

  rr_prio_arbiter #(.NUM(3)) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_i      (mode3),
    .req_i       (req3),
    .ack_i       (ack3),
    .gnt_o       (gnt3),
    .gnt_valid_o (vld3),
    .gnt_idx_o   (idx3)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rr_seq4 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0] rr_idx4 [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [2:0] rr_seq3 [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    idx4_unused_guard = '0;
    rst_n = 1'b0;
    mode4 = 1'b0; ack4 = 1'b0; req4 = 4'b1111;
    mode3 = 1'b1; ack3 = 1'b0; req3 = 3'b000;

    // Reset held with all requests high
    tick(); tick();
    chk_eq("rst_gnt", 32'(gnt4), 32'h0);
    chk_eq("rst_vld", 32'(vld4), 32'h0);
    chk_eq("rst_idx", 32'(idx4), 32'h0);
    chk_eq("rst_gnt3", 32'(gnt3), 32'h0);
    rst_n = 1'b1;
    tick();
    chk_eq("rel_gnt", 32'(gnt4), 32'h1);
    chk_eq("rel_vld", 32'(vld4), 32'h1);

    // Fixed priority: index 1 always beats index 3
    req4 = 4'b1010; ack4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq($sformatf("fix_gnt%0d", i), 32'(gnt4), 32'h2);
      chk_eq($sformatf("fix_idx%0d", i), 32'(idx4), 32'h1);
    end

    // Withdraw to idle, then round-robin over all four
    req4 = 4'b0000; ack4 = 1'b0;
    tick();
    chk_eq("wd_idle", 32'(gnt4), 32'h0);
    chk_eq("wd_vld", 32'(vld4), 32'h0);
    mode4 = 1'b1; req4 = 4'b1111; ack4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_eq($sformatf("rr_gnt%0d", i), 32'(gnt4), 32'(rr_seq4[i]));
      chk_eq($sformatf("rr_idx%0d", i), 32'(idx4), 32'(rr_idx4[i]));
    end

    // Hold while other requests toggle, then withdraw
    req4 = 4'b0000; ack4 = 1'b0;
    tick();
    chk_eq("hold_pre_idle", 32'(gnt4), 32'h0);
    req4 = 4'b0110;
    tick();
    chk_eq("hold_first", 32'(gnt4), 32'h2);
    for (int i = 0; i < 5; i++) begin
      req4[2] = ~req4[2];
      mode4   = ~mode4;
      tick();
      chk_eq($sformatf("hold_gnt%0d", i), 32'(gnt4), 32'h2);
    end
    mode4 = 1'b1;
    req4  = 4'b0100;
    tick();
    chk_eq("hold_drop", 32'(gnt4), 32'h0);
    req4 = 4'b0110;
    tick();
    chk_eq("hold_regrant", 32'(gnt4), 32'h2);

    // Pointer to 3, then a lone request at 0 wraps the scan
    req4 = 4'b0100; ack4 = 1'b1;
    tick();
    chk_eq("wrap_g2", 32'(gnt4), 32'h4);
    req4 = 4'b0000;
    tick();
    chk_eq("wrap_idle", 32'(gnt4), 32'h0);
    req4 = 4'b0001; ack4 = 1'b0;
    tick();
    chk_eq("wrap_g0", 32'(gnt4), 32'h1);
    req4 = 4'b0011; ack4 = 1'b1;
    tick();
    chk_eq("wrap_ptr1", 32'(gnt4), 32'h2);

    // NUM=3 round robin must wrap 2 -> 0
    req3 = 3'b111; ack3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq($sformatf("n3_gnt%0d", i), 32'(gnt3), 32'(rr_seq3[i]));
    end
    chk_eq("n3_idx", 32'(idx3), 32'h0);

    // Async reset mid-grant, then arbitration restarts from pointer 0
    req4 = 4'b1111; ack4 = 1'b0;
    tick();
    chk_eq("ar_hold", 32'(gnt4), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("ar_gnt", 32'(gnt4), 32'h0);
    chk_eq("ar_vld", 32'(vld4), 32'h0);
    chk_eq("ar_idx", 32'(idx4), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk_eq("ar_restart", 32'(gnt4), 32'h1);
    chk_eq("ar_restart_idx", 32'(idx4), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_prio_arbiter.md
Name: rr_prio_arbiter

Overview:
Parametrised, registered arbiter for NUM requesters with a run-time choice of fixed-priority or round-robin policy. A grant is held as a locked transaction until the consumer acknowledges it or the winner withdraws its request. It replaces purely combinational fixed-priority arbitration at shared-resource front ends, where grant stability and fairness are required.

Parameters:
NUM, 4, number of requesters (>= 2).
IDX_W, $clog2(NUM), width of grant index and round-robin pointer (derived, not overridden).

Ports:
clk_i  input  1  clock, all state on rising edge.
rst_ni  input  1  asynchronous active-low reset.
mode_i  input  1  0 = fixed priority (index 0 highest), 1 = round robin.
req_i  input  NUM  per-requester request level.
ack_i  input  1  consumer completes current granted transaction.
gnt_o  output  NUM  registered one-hot grant (all-zero when idle).
gnt_valid_o  output  1  high iff gnt_o non-zero.
gnt_idx_o  output  IDX_W  binary index of granted requester (0 when idle).

Behaviour:
- Reset (async assert, sync deassert handled upstream): gnt_o=0, gnt_valid_o=0, gnt_idx_o=0, rr pointer=0, state IDLE. Reset mid-grant clears outputs immediately.
- States: IDLE, GRANT.
- Arbitration point: any cycle in IDLE, or a cycle in GRANT with ack_i=1. mode_i is sampled only at arbitration points.
- Fixed mode: winner is the lowest set index of req_i.
- RR mode: winner is the first set index scanning from ptr upward, wrapping NUM-1 -> 0.
- Arbitration at cycle t with req_i != 0: winner visible on gnt_o at t+1 (one-cycle latency), state GRANT. With req_i == 0: stay/go IDLE, outputs zero at t+1.
- GRANT hold: while ack_i=0 and req_i[winner]=1, gnt_o and gnt_idx_o are stable regardless of other req_i changes or mode_i changes.
- Ack: ack_i=1 in GRANT at t: in RR mode ptr <= (winner+1) mod NUM; arbitrate the same cycle using the updated ptr; back-to-back grants have no bubble. In fixed mode ptr is unchanged.
- Withdrawal: req_i[winner]=0 and ack_i=0 in GRANT at t: gnt_o=0 at t+1, state IDLE, ptr unchanged. Withdrawal with ack_i=1 in the same cycle counts as ack.
- ack_i in IDLE is ignored.
- Invariants: $onehot0(gnt_o); gnt_valid_o == |gnt_o; gnt_o[k] at t+1 implies req_i[k] at t; ptr < NUM.
- Starvation bound in RR mode with continuous ack: a requester holding req high is granted within NUM arbitration points.
- Non-power-of-two NUM: pointer wrap uses an explicit compare to NUM-1, never relying on natural overflow.

Decomposition:
- Package arb_pkg: arb_mode_e {ARB_FIXED=0, ARB_RR=1} and arb_state_e {ARB_IDLE, ARB_GRANT}.
- Sub-module prio_pick: combinational, parameter NUM. Inputs are the request vector and a start index. Outputs are a one-hot winner, the winner index and an any flag, using the rotate, lowest-set, unrotate method. Fixed mode drives the start index to 0.
- SVA bind module rr_prio_arbiter_sva carries the invariants above.

Test Plan:
- Reset: drive rst_ni=0 with req_i=4'b1111 -> gnt_o=0, gnt_valid_o=0, gnt_idx_o=0 while reset is low; then rst_ni=1 -> gnt_o=4'b0001 on the first edge after arbitration.
- Fixed mode: req_i=4'b1010, ack every grant cycle -> gnt_o=4'b0010 repeatedly; index 3 is never granted.
- RR fairness: mode_i=1, req_i=4'b1111, ack_i=1 every grant cycle -> gnt_o sequence 0001, 0010, 0100, 1000, 0001 with no idle cycles.
- Hold and withdrawal: RR mode, req_i=4'b0110 -> gnt_o=0010. Hold ack_i=0 for 5 cycles while req_i toggles bit 2 -> gnt_o stays 0010. Drop req_i[1] -> gnt_o=0 next cycle. Next grant is 0100 only if ptr had advanced; with ptr=0 it is 0010 again.
- Wrap: RR mode, ptr at 3, req_i=4'b0001 -> grant 0001 and ptr becomes 1 after ack. Run again with NUM=3 and confirm ptr goes 2 -> 0.
- Async reset mid-GRANT: assert rst_ni=0 between clock edges -> gnt_o=0 immediately; after release, arbitration restarts from ptr=0.
